conv2d_axi_master_seq: RTL

Hardware AXI4-Lite master that drives the conv2d AXI4-Lite accelerator slave in place of CPU software. It accepts one 3x3 window plus 3x3 kernel per job on a valid/ready port and writes the nine pixels and nine weights into the slave register map. It then sets start, polls done, reads the result, and returns it on a result valid/ready port. It sits directly upstream of the accelerator slave, between the line-buffer/window generator and the AXI interconnect.

---
 rtl/conv2d_axi_master_seq.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/conv2d_axi_master_seq.sv
// AXI4-Lite master that loads one 3x3 window and kernel into the conv2d slave, starts it, polls done and returns the result.
// Optional feature: define CONV_SEQ_WEIGHT_CACHE_EN to skip rewriting weights that match the last successfully written set.
module conv2d_axi_master_seq #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 7,
  parameter int POLL_MAX           = 16
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          job_valid,
  output logic                          job_ready,
  input  logic [71:0]                   job_pixels,
  input  logic [71:0]                   job_weights,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [15:0]                   res_data,
  output logic [1:0]                    res_err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int PW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_WR_B    = 3'd2;
  localparam logic [2:0] S_POLL_AR = 3'd3;
  localparam logic [2:0] S_POLL_R  = 3'd4;
  localparam logic [2:0] S_RES_AR  = 3'd5;
  localparam logic [2:0] S_RES_R   = 3'd6;
  localparam logic [2:0] S_OUT     = 3'd7;

  logic [2:0]    state;
  logic [143:0]  job_q;     // {weights, pixels}: write index i selects byte i
  logic [4:0]    idx;
  logic [PW-1:0] poll_cnt;
  logic          issued, aw_done, w_done;
  logic [7:0]    wr_byte;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          aw_hs, w_hs, ar_hs;
  logic          b_err, r_err, poll_timeout, err_any, skip_now;
  logic          unused_rdata;

  assign unused_rdata = ^M_AXI_RDATA[DW-1:16];

  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
  assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;

  assign M_AXI_BREADY = (state == S_WR_B);
  assign M_AXI_RREADY = (state == S_POLL_R) || (state == S_RES_R);
  assign res_valid    = (state == S_OUT);

  assign b_err        = (state == S_WR_B) && M_AXI_BVALID && (M_AXI_BRESP != 2'b00);
  assign r_err        = M_AXI_RREADY && M_AXI_RVALID && (M_AXI_RRESP != 2'b00);
  assign poll_timeout = (state == S_POLL_R) && M_AXI_RVALID && (M_AXI_RRESP == 2'b00) &&
                        !M_AXI_RDATA[1] && (poll_cnt == PW'(POLL_MAX - 1));
  assign err_any      = b_err || r_err || poll_timeout;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_byte = 8'h00;
    wr_addr = '0;
    wr_data = DW'(1);
    if (idx != 5'd18) begin
      wr_byte = job_q[{idx, 3'b000} +: 8];
      wr_addr = AW'({idx, 2'b00} + 7'd4);
      wr_data = DW'($signed(wr_byte));
    end
  end

  // NOTE: job_q carries data only; its validity is implied by the state, so it needs no reset.
  always_ff @(posedge M_AXI_ACLK) begin
    if (job_valid && job_ready) job_q <= {job_weights, job_pixels};
  end

`ifdef CONV_SEQ_WEIGHT_CACHE_EN
  logic [71:0] wcache;
  logic        wcache_vld, skip_w;

  assign skip_now = skip_w && (idx == 5'd8);

  always_ff @(posedge M_AXI_ACLK) begin
    if (state == S_WR_B && M_AXI_BVALID && M_AXI_BRESP == 2'b00 && idx == 5'd17)
      wcache <= job_q[143:72];
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      wcache_vld <= 1'b0;
      skip_w     <= 1'b0;
    end else begin
      if (job_valid && job_ready) skip_w <= wcache_vld && (job_weights == wcache);
      if (state == S_WR_B && M_AXI_BVALID && M_AXI_BRESP == 2'b00 && idx == 5'd17)
        wcache_vld <= 1'b1;
      if (err_any) wcache_vld <= 1'b0;
    end
  end
`else
  assign skip_now = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state         <= S_IDLE;
      job_ready     <= 1'b0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_WDATA   <= '0;
      M_AXI_ARADDR  <= '0;
      res_data      <= '0;
      res_err       <= 2'b00;
      idx           <= '0;
      poll_cnt      <= '0;
      issued        <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (job_valid && job_ready) begin
            job_ready <= 1'b0;
            idx       <= '0;
            issued    <= 1'b0;
            res_err   <= 2'b00;
            state     <= S_WR;
          end else begin
            job_ready <= 1'b1;
          end
        end
        S_WR: begin
          if (!issued) begin
            issued        <= 1'b1;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            M_AXI_AWADDR  <= wr_addr;
            M_AXI_WDATA   <= wr_data;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
          end else begin
            if (aw_hs) begin
              M_AXI_AWVALID <= 1'b0;
              aw_done       <= 1'b1;
            end
            if (w_hs) begin
              M_AXI_WVALID <= 1'b0;
              w_done       <= 1'b1;
            end
            if ((aw_done || aw_hs) && (w_done || w_hs)) begin
              issued <= 1'b0;
              state  <= S_WR_B;
            end
          end
        end
        S_WR_B: begin
          if (M_AXI_BVALID) begin
            if (b_err) begin
              res_data <= '0;
              res_err  <= 2'b01;
              state    <= S_OUT;
            end else if (idx == 5'd18) begin
              poll_cnt <= '0;
              state    <= S_POLL_AR;
            end else begin
              idx   <= skip_now ? 5'd18 : idx + 5'd1;
              state <= S_WR;
            end
          end
        end
        S_POLL_AR, S_RES_AR: begin
          if (!issued) begin
            issued        <= 1'b1;
            M_AXI_ARVALID <= 1'b1;
            M_AXI_ARADDR  <= (state == S_RES_AR) ? AW'(7'h4C) : '0;
          end else if (ar_hs) begin
            issued        <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            state         <= (state == S_RES_AR) ? S_RES_R : S_POLL_R;
          end
        end
        S_POLL_R: begin
          if (M_AXI_RVALID) begin
            if (r_err || poll_timeout) begin
              res_data <= '0;
              res_err  <= r_err ? 2'b01 : 2'b10;
              state    <= S_OUT;
            end else if (M_AXI_RDATA[1]) begin
              state <= S_RES_AR;
            end else begin
              poll_cnt <= poll_cnt + PW'(1);
              state    <= S_POLL_AR;
            end
          end
        end
        S_RES_R: begin
          if (M_AXI_RVALID) begin
            res_data <= r_err ? 16'h0000 : M_AXI_RDATA[15:0];
            res_err  <= r_err ? 2'b01 : 2'b00;
            state    <= S_OUT;
          end
        end
        S_OUT: begin
          if (res_ready) begin
            job_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
